// File: rtl/shared_types_pkg.sv
// Shared types for the ALU sharing path: op encoding, request payload and small helpers.
package shared_types_pkg;

  localparam int unsigned ALU_XLEN = 64;
  localparam int unsigned ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_SH1ADD = 5'd10,
    ALU_SH2ADD = 5'd11,
    ALU_SH3ADD = 5'd12,
    ALU_ADDW   = 5'd13,
    ALU_SUBW   = 5'd14,
    ALU_SLLW   = 5'd15,
    ALU_SRLW   = 5'd16,
    ALU_SRAW   = 5'd17
  } alu_op_t;

  localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = 5'd17;

  // Raw op code is kept so that undefined encodings reach the ALU unchanged.
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
  } alu_req_t;

  function automatic logic [ALU_XLEN-1:0] sext_w(input logic [31:0] v);
    return {{(ALU_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV64I/Zba ALU. Shift-add ops exist only when ALU_ZBA_EN is defined.
module alu_core
  import shared_types_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [ALU_XLEN-1:0] a,
  input  logic [ALU_XLEN-1:0] b,
  output logic [ALU_XLEN-1:0] result,
  output logic                illegal
);

  logic [31:0] w;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    w       = '0;
    if (op > ALU_OP_LAST) begin
      illegal = 1'b1;
    end else begin
      case (op)
        ALU_ADD:  result = a + b;
        ALU_SUB:  result = a - b;
        ALU_AND:  result = a & b;
        ALU_OR:   result = a | b;
        ALU_XOR:  result = a ^ b;
        ALU_SLL:  result = a << b[5:0];
        ALU_SRL:  result = a >> b[5:0];
        ALU_SRA:  result = $signed(a) >>> b[5:0];
        ALU_SLT:  result = ALU_XLEN'($signed(a) < $signed(b));
        ALU_SLTU: result = ALU_XLEN'(a < b);
`ifdef ALU_ZBA_EN
        ALU_SH1ADD: result = {a[ALU_XLEN-2:0], 1'b0} + b;
        ALU_SH2ADD: result = {a[ALU_XLEN-3:0], 2'b0} + b;
        ALU_SH3ADD: result = {a[ALU_XLEN-4:0], 3'b0} + b;
`endif
        // Word ops compute on the low half and sign-extend bit 31.
        ALU_ADDW: begin w = a[31:0] + b[31:0];              result = sext_w(w); end
        ALU_SUBW: begin w = a[31:0] - b[31:0];              result = sext_w(w); end
        ALU_SLLW: begin w = a[31:0] << b[4:0];              result = sext_w(w); end
        ALU_SRLW: begin w = a[31:0] >> b[4:0];              result = sext_w(w); end
        ALU_SRAW: begin w = $signed(a[31:0]) >>> b[4:0];    result = sext_w(w); end
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between EX (req 0) and AGU (req 1); optional Zba via ALU_ZBA_EN.
module alu_share_arbiter
  import shared_types_pkg::*;
#(
  parameter int unsigned XLEN  = ALU_XLEN,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][ALU_OP_W-1:0]   req_op,
  input  logic [1:0][XLEN-1:0]       req_a,
  input  logic [1:0][XLEN-1:0]       req_b,
  input  logic [1:0][TAG_W-1:0]      req_tag,
  output logic [1:0]                 resp_valid,
  input  logic [1:0]                 resp_ready,
  output logic [1:0][XLEN-1:0]       resp_result,
  output logic [1:0][TAG_W-1:0]      resp_tag,
  output logic [1:0]                 resp_illegal
);

  logic                rr_ptr_q;
  logic [1:0]          avail_c;
  logic [1:0]          elig_c;
  logic [1:0]          grant_c;
  logic                sel_c;
  alu_req_t [1:0]      req_c;
  alu_req_t            req_mux_c;
  logic [XLEN-1:0]     alu_result_c;
  logic                alu_illegal_c;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_c[i].op = req_op[i];
      req_c[i].a  = req_a[i];
      req_c[i].b  = req_b[i];
    end
  end

  // A full slot still accepts when it is being drained this cycle.
  assign avail_c = ~resp_valid | resp_ready;
  assign elig_c  = req_valid & avail_c;

  always_comb begin
    grant_c = '0;
    if (!rst_n)
      grant_c = '0;
    else if (elig_c == 2'b11)
      grant_c = rr_ptr_q ? 2'b10 : 2'b01;
    else
      grant_c = elig_c;
  end

  assign req_ready = grant_c;
  assign sel_c     = grant_c[1];
  assign req_mux_c = req_c[sel_c];

  alu_core u_alu_core (
    .op      (req_mux_c.op),
    .a       (req_mux_c.a),
    .b       (req_mux_c.b),
    .result  (alu_result_c),
    .illegal (alu_illegal_c)
  );

  // Round-robin pointer and the two response slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 1'b0;
      resp_valid   <= '0;
      resp_result  <= '0;
      resp_tag     <= '0;
      resp_illegal <= '0;
    end else begin
      if (elig_c == 2'b11) rr_ptr_q <= ~rr_ptr_q;
      for (int i = 0; i < 2; i++) begin
        if (grant_c[i]) begin
          resp_valid[i]   <= 1'b1;
          resp_result[i]  <= alu_result_c;
          resp_tag[i]     <= req_tag[i];
          resp_illegal[i] <= alu_illegal_c;
        end else if (resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic [1:0]             hold_q;
  alu_req_t [1:0]         prev_req_q;
  logic [1:0][TAG_W-1:0]  prev_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= req_valid & ~req_ready;
  end

  always_ff @(posedge clk) begin
    prev_req_q <= req_c;
    prev_tag_q <= req_tag;
  end

  // A stalled requester must keep its payload stable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && hold_q[i] && req_valid[i])
        assert (req_c[i] == prev_req_q[i] && req_tag[i] == prev_tag_q[i])
          else $error("request %0d payload changed while stalled", i);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter; expected values follow ALU_ZBA_EN.
module tb_alu_share_arbiter;
  import shared_types_pkg::*;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    logic [63:0] res;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  tag;
    logic        ill;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][4:0]   req_op;
  logic [1:0][63:0]  req_a;
  logic [1:0][63:0]  req_b;
  logic [1:0][3:0]   req_tag;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [1:0][63:0]  resp_result;
  logic [1:0][3:0]   resp_tag;
  logic [1:0]        resp_illegal;

  alu_share_arbiter #(.XLEN(64), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_tag     (resp_tag),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   idx0  = 0;
  int   idx1  = 0;
  vec_t v0 [N];
  vec_t v1 [N];
  exp_t cur_exp0, cur_exp1, e0, e1;
  exp_t q0 [$];
  exp_t q1 [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] tag, input logic [63:0] res, input logic ill);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res; v.ill = ill;
    return v;
  endfunction

  // Monitor: pop and compare on every consumed response, record every acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid[0] && resp_ready[0]) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL resp0_unexpected: got result %h want no response", resp_result[0]);
        end else begin
          e0 = q0.pop_front();
          chk("resp0_result",  resp_result[0],       e0.res);
          chk("resp0_tag",     64'(resp_tag[0]),     64'(e0.tag));
          chk("resp0_illegal", 64'(resp_illegal[0]), 64'(e0.ill));
        end
      end
      if (resp_valid[1] && resp_ready[1]) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL resp1_unexpected: got result %h want no response", resp_result[1]);
        end else begin
          e1 = q1.pop_front();
          chk("resp1_result",  resp_result[1],       e1.res);
          chk("resp1_tag",     64'(resp_tag[1]),     64'(e1.tag));
          chk("resp1_illegal", 64'(resp_illegal[1]), 64'(e1.ill));
        end
      end
      if (req_valid[0] && req_ready[0]) q0.push_back(cur_exp0);
      if (req_valid[1] && req_ready[1]) q1.push_back(cur_exp1);
    end
  end

  task automatic drive(input logic [1:0] m);
    if (m[0]) begin
      req_op[0] = v0[idx0].op; req_a[0] = v0[idx0].a; req_b[0] = v0[idx0].b; req_tag[0] = v0[idx0].tag;
      cur_exp0.res = v0[idx0].res; cur_exp0.tag = v0[idx0].tag; cur_exp0.ill = v0[idx0].ill;
    end
    if (m[1]) begin
      req_op[1] = v1[idx1].op; req_a[1] = v1[idx1].a; req_b[1] = v1[idx1].b; req_tag[1] = v1[idx1].tag;
      cur_exp1.res = v1[idx1].res; cur_exp1.tag = v1[idx1].tag; cur_exp1.ill = v1[idx1].ill;
    end
    req_valid = m;
  endtask

  // One clock: present requests, check the grant, advance on handshake, check latency.
  task automatic run_cycle(input logic [1:0] mask, input logic [1:0] rr, input logic [1:0] exp_rdy,
                           input string nm);
    logic [1:0] m, acc;
    m = mask;
    if (idx0 >= N) m[0] = 1'b0;
    if (idx1 >= N) m[1] = 1'b0;
    drive(m);
    resp_ready = rr;
    @(negedge clk);
    chk($sformatf("%s_ready", nm), 64'(req_ready), 64'(exp_rdy));
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    if (acc[0]) begin idx0++; chk($sformatf("%s_lat0", nm), 64'(resp_valid[0]), 64'd1); end
    if (acc[1]) begin idx1++; chk($sformatf("%s_lat1", nm), 64'(resp_valid[1]), 64'd1); end
  endtask

  initial begin
    v0[0] = mk(ALU_ADD,  64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 4'd3, 64'd2, 1'b0);
    v0[1] = mk(ALU_SUBW, 64'd0, 64'd1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    v0[2] = mk(ALU_SRAW, 64'h8000_0000, 64'd4, 4'd5, 64'hFFFF_FFFF_F800_0000, 1'b0);
    v0[3] = mk(ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd6, 64'd1, 1'b0);
    v0[4] = mk(ALU_SLL,  64'd1, 64'h43, 4'd7, 64'd8, 1'b0);
`ifdef ALU_ZBA_EN
    v0[5] = mk(ALU_SH2ADD, 64'd3, 64'd1, 4'd11, 64'd13, 1'b0);
`else
    v0[5] = mk(ALU_SH2ADD, 64'd3, 64'd1, 4'd11, 64'd0, 1'b1);
`endif
    v0[6] = mk(ALU_AND,  64'hFF0, 64'h0F0, 4'd14, 64'hF0, 1'b0);
    v0[7] = mk(ALU_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd1, 64'd0, 1'b0);

    v1[0] = mk(ALU_ADD,  64'd10, 64'd20, 4'd1, 64'd30, 1'b0);
    v1[1] = mk(ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, 64'd0, 1'b0);
    v1[2] = mk(ALU_SRA,  64'h8000_0000_0000_0000, 64'd4, 4'd8, 64'hF800_0000_0000_0000, 1'b0);
    v1[3] = mk(ALU_XOR,  64'hFF00, 64'h0FF0, 4'd9, 64'hF0F0, 1'b0);
    v1[4] = mk(ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 4'd10, 64'hFFFF_FFFF_8000_0000, 1'b0);
    v1[5] = mk(5'd20,    64'd1, 64'd1, 4'd12, 64'd0, 1'b1);
    v1[6] = mk(ALU_OR,   64'hF0, 64'h0F, 4'd13, 64'hFF, 1'b0);
    v1[7] = mk(ALU_SUB,  64'd0, 64'd1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Reset with both requesters valid.
    rst_n = 1'b0;
    resp_ready = 2'b11;
    drive(2'b11);
    @(negedge clk);
    chk("rst_ready",   64'(req_ready),    64'd0);
    chk("rst_valid",   64'(resp_valid),   64'd0);
    chk("rst_result0", resp_result[0],    64'd0);
    chk("rst_result1", resp_result[1],    64'd0);
    chk("rst_tag",     64'(resp_tag),     64'd0);
    chk("rst_illegal", 64'(resp_illegal), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention with both slots draining: strict alternation starting at requester 0.
    for (int c = 0; c < 8; c++)
      run_cycle(2'b11, 2'b11, (c % 2 == 0) ? 2'b01 : 2'b10, $sformatf("alt%0d", c));

    // Slot 0 left full blocks only requester 0; then drain and refill together.
    run_cycle(2'b11, 2'b10, 2'b01, "blk_tie");
    run_cycle(2'b11, 2'b10, 2'b10, "blk_a");
    run_cycle(2'b11, 2'b10, 2'b10, "blk_b");
    chk("blk_hold_valid",  64'(resp_valid[0]), 64'd1);
    chk("blk_hold_result", resp_result[0],     64'd8);
    run_cycle(2'b01, 2'b11, 2'b01, "drain_refill");
    run_cycle(2'b10, 2'b01, 2'b10, "fill1");
    run_cycle(2'b01, 2'b00, 2'b01, "fill0");
    chk("both_full", 64'(resp_valid), 64'd3);

    // Asynchronous reset with both slots full; in-flight results are dropped.
    drive(2'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  64'(resp_valid),   64'd0);
    chk("mid_rst_ready",  64'(req_ready),    64'd0);
    chk("mid_rst_result", resp_result[0] | resp_result[1], 64'd0);
    chk("mid_rst_tag",    64'(resp_tag),     64'd0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle(2'b11, 2'b11, 2'b01, "post_rst_tie");
    run_cycle(2'b11, 2'b11, 2'b10, "post_rst_r1");
    run_cycle(2'b00, 2'b11, 2'b00, "idle0");
    run_cycle(2'b00, 2'b11, 2'b00, "idle1");

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
